// File: rtl/stage_ex.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier, registered result.
// Optional macro EX_FWD_EN enables operand forwarding from this stage's registered output.
module stage_ex #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic                  reg_wr,
    input  logic [REG_ADDR_W-1:0] reg_addr_rd,
    input  logic [REG_ADDR_W-1:0] reg_addr_r1,
    input  logic [REG_ADDR_W-1:0] reg_addr_r2,
    input  logic [DATA_W-1:0]     reg_data_r1,
    input  logic [DATA_W-1:0]     reg_data_r2,
    output logic                  out_busy,
    output logic                  out_flush,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [DATA_W-1:0]     out_result
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(10);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_acc;
    logic [DATA_W-1:0]       r_mcand;
    logic [DATA_W-1:0]       r_mplier;
    logic [REG_ADDR_W-1:0]   r_mul_rd;
    logic                    r_mul_wr;
    logic                    r_out_flush;
    logic                    r_out_wr;
    logic [REG_ADDR_W-1:0]   r_out_rd;
    logic [DATA_W-1:0]       r_out_result;

    logic [DATA_W-1:0]       w_op1;
    logic [DATA_W-1:0]       w_op2;
    logic [DATA_W-1:0]       w_alu;
    logic                    w_legal;
    logic [DATA_W-1:0]       w_acc_step;
    logic                    w_out_ld;
    logic                    w_nx_flush;
    logic                    w_nx_wr;
    logic [REG_ADDR_W-1:0]   w_nx_rd;
    logic [DATA_W-1:0]       w_nx_result;
    logic                    w_mul_start;
    logic                    w_mul_step;

`ifdef EX_FWD_EN
    // Only a real, writing, non-x0 result in the output register may be forwarded.
    logic w_fwd_ok;
    assign w_fwd_ok = r_out_wr && !r_out_flush && (r_out_rd != {REG_ADDR_W{1'b0}});
    assign w_op1    = (w_fwd_ok && (r_out_rd == reg_addr_r1)) ? r_out_result : reg_data_r1;
    assign w_op2    = (w_fwd_ok && (r_out_rd == reg_addr_r2)) ? r_out_result : reg_data_r2;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{reg_addr_r1, reg_addr_r2};
    assign w_op1         = reg_data_r1;
    assign w_op2         = reg_data_r2;
`endif

    assign w_legal    = (alu_op <= OP_MUL);
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle ALU
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        case (alu_op)
            OP_ADD:  w_alu = w_op1 + w_op2;
            OP_SUB:  w_alu = w_op1 - w_op2;
            OP_AND:  w_alu = w_op1 & w_op2;
            OP_OR:   w_alu = w_op1 | w_op2;
            OP_XOR:  w_alu = w_op1 ^ w_op2;
            OP_SLL:  w_alu = w_op1 << w_op2[SH_W-1:0];
            OP_SRL:  w_alu = w_op1 >> w_op2[SH_W-1:0];
            OP_SRA:  w_alu = $unsigned($signed(w_op1) >>> w_op2[SH_W-1:0]);
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_op1 < w_op2)};
            default: w_alu = {DATA_W{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_state_nx;
        end else begin
            r_state <= r_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!flush && !stall && (alu_op == OP_MUL)) w_state_nx = ST_MUL;
                else                                         w_state_nx = ST_IDLE;
            end
            ST_MUL: begin
                if (flush)                  w_state_nx = ST_IDLE;
                else if (r_cnt == CNT_LAST) w_state_nx = ST_DONE;
                else                        w_state_nx = ST_MUL;
            end
            ST_DONE: begin
                if (flush || !stall) w_state_nx = ST_IDLE;
                else                 w_state_nx = ST_DONE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: output-register load values and multiplier controls
    always_comb begin
        w_out_ld    = 1'b0;
        w_nx_flush  = 1'b1;
        w_nx_wr     = 1'b0;
        w_nx_rd     = {REG_ADDR_W{1'b0}};
        w_nx_result = {DATA_W{1'b0}};
        w_mul_start = 1'b0;
        w_mul_step  = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        w_out_ld = 1'b1;
                    end else if (stall) begin
                        w_out_ld = 1'b0;
                    end else if (alu_op == OP_MUL) begin
                        w_out_ld    = 1'b1;
                        w_mul_start = 1'b1;
                    end else begin
                        w_out_ld    = 1'b1;
                        w_nx_flush  = 1'b0;
                        w_nx_wr     = reg_wr && w_legal;
                        w_nx_rd     = reg_addr_rd;
                        w_nx_result = w_alu;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        w_out_ld = 1'b1;
                    end else begin
                        w_mul_step = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush) begin
                        w_out_ld = 1'b1;
                    end else if (!stall) begin
                        w_out_ld    = 1'b1;
                        w_nx_flush  = 1'b0;
                        w_nx_wr     = r_mul_wr;
                        w_nx_rd     = r_mul_rd;
                        w_nx_result = r_acc;
                    end else begin
                        w_out_ld = 1'b0;
                    end
                end
                default: w_out_ld = 1'b0;
            endcase
        end else begin
            w_out_ld = 1'b0;
        end
    end

    // Registered stage outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_flush  <= 1'b1;
            r_out_wr     <= 1'b0;
            r_out_rd     <= {REG_ADDR_W{1'b0}};
            r_out_result <= {DATA_W{1'b0}};
        end else if (w_out_ld) begin
            r_out_flush  <= w_nx_flush;
            r_out_wr     <= w_nx_wr;
            r_out_rd     <= w_nx_rd;
            r_out_result <= w_nx_result;
        end
    end

    // Shift-add multiplier: one multiplier bit consumed per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {DATA_W{1'b0}};
            r_mcand  <= {DATA_W{1'b0}};
            r_mplier <= {DATA_W{1'b0}};
            r_mul_rd <= {REG_ADDR_W{1'b0}};
            r_mul_wr <= 1'b0;
        end else if (w_mul_start) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {DATA_W{1'b0}};
            r_mcand  <= w_op1;
            r_mplier <= w_op2;
            r_mul_rd <= reg_addr_rd;
            r_mul_wr <= reg_wr;
        end else if (w_mul_step) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign out_busy        = (r_state != ST_IDLE);
    assign out_flush       = r_out_flush;
    assign out_reg_wr      = r_out_wr;
    assign out_reg_addr_rd = r_out_rd;
    assign out_result      = r_out_result;
endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: driver queues expected writebacks, monitor compares each new output.
module tb_stage_ex;
    logic        clk = 1'b0;
    logic        rst, en, stall, flush, reg_wr;
    logic [3:0]  alu_op;
    logic [4:0]  reg_addr_rd, reg_addr_r1, reg_addr_r2;
    logic [31:0] reg_data_r1, reg_data_r2;
    logic        out_busy, out_flush, out_reg_wr;
    logic [4:0]  out_reg_addr_rd;
    logic [31:0] out_result;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] res;
        string       nm;
    } exp_t;
    exp_t q[$];

    stage_ex dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
        .alu_op(alu_op), .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd),
        .reg_addr_r1(reg_addr_r1), .reg_addr_r2(reg_addr_r2),
        .reg_data_r1(reg_data_r1), .reg_data_r2(reg_data_r2),
        .out_busy(out_busy), .out_flush(out_flush), .out_reg_wr(out_reg_wr),
        .out_reg_addr_rd(out_reg_addr_rd), .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic bubble();
        flush  = 1'b1;
        alu_op = 4'd0;
        reg_wr = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d1, input logic [31:0] d2,
                       input logic wr, input logic exp_wr, input logic [31:0] exp_res,
                       input string nm);
        flush = 1'b0; alu_op = op; reg_wr = wr; reg_addr_rd = rd;
        reg_addr_r1 = a1; reg_addr_r2 = a2; reg_data_r1 = d1; reg_data_r2 = d2;
        q.push_back('{exp_wr, rd, exp_res, nm});
        tick();
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int stall_len, input int en_gap,
                           input int exp_busy, input string nm);
        int busy_cnt = 0;
        flush = 1'b0; stall = 1'b0; en = 1'b1; alu_op = 4'd10; reg_wr = 1'b1;
        reg_addr_rd = rd; reg_addr_r1 = 5'd0; reg_addr_r2 = 5'd0;
        reg_data_r1 = a; reg_data_r2 = b;
        q.push_back('{1'b1, rd, exp_res, nm});
        tick();
        check({nm, "_issue_bubble"}, {31'd0, out_flush}, 32'd1);
        for (int k = 1; k <= 80; k++) begin
            if (!out_busy) break;
            busy_cnt++;
            stall = (k >= 33) && (k < 33 + stall_len);
            en    = !((k >= 11) && (k < 11 + en_gap));
            tick();
        end
        stall = 1'b0; en = 1'b1;
        bubble();
        check({nm, "_busy_cycles"}, busy_cnt, exp_busy);
        check({nm, "_valid_at_drop"}, {31'd0, out_flush}, 32'd0);
        tick();
    endtask

    // Monitor: compare every newly presented non-bubble output against the queue head
    initial begin : monitor
        logic        prev_valid;
        logic [37:0] prev_tuple;
        exp_t        e;
        prev_valid = 1'b0;
        prev_tuple = 38'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else if (!out_flush &&
                         (!prev_valid || ({out_reg_wr, out_reg_addr_rd, out_result} != prev_tuple))) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got wr=%0d rd=%0d res=%h, want none",
                             out_reg_wr, out_reg_addr_rd, out_result);
                end else begin
                    e = q.pop_front();
                    if (out_reg_wr !== e.wr || out_reg_addr_rd !== e.rd || out_result !== e.res) begin
                        n_err++;
                        $display("FAIL %s: got wr=%0d rd=%0d res=%h, want wr=%0d rd=%0d res=%h",
                                 e.nm, out_reg_wr, out_reg_addr_rd, out_result, e.wr, e.rd, e.res);
                    end
                end
            end
            prev_valid = !out_flush;
            prev_tuple = {out_reg_wr, out_reg_addr_rd, out_result};
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b1; reg_wr = 1'b0; alu_op = 4'd0;
        reg_addr_rd = 5'd0; reg_addr_r1 = 5'd0; reg_addr_r2 = 5'd0;
        reg_data_r1 = 32'd0; reg_data_r2 = 32'd0;
        tick(); tick();
        check("rst_flush",  {31'd0, out_flush},  32'd1);
        check("rst_wr",     {31'd0, out_reg_wr}, 32'd0);
        check("rst_result", out_result,          32'd0);
        check("rst_busy",   {31'd0, out_busy},   32'd0);
        rst = 1'b0;
        tick();

        alu(4'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'd5, 1'b1, 1'b1, 32'd12, "add");
        check("add_latency", out_result, 32'd12);
        alu(4'd1, 5'd2, 5'd0, 5'd0, 32'd3, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFFE, "sub");
        alu(4'd2, 5'd3, 5'd0, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 1'b1, 32'h00F0_1234, "and");
        alu(4'd3, 5'd4, 5'd0, 5'd0, 32'hF000_0000, 32'h0000_000F, 1'b1, 1'b1, 32'hF000_000F, "or");
        alu(4'd4, 5'd5, 5'd0, 5'd0, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 1'b1, 32'h5555_5555, "xor");
        alu(4'd5, 5'd6, 5'd0, 5'd0, 32'd1, 32'h0000_0023, 1'b1, 1'b1, 32'd8, "sll_low5");
        alu(4'd6, 5'd7, 5'd0, 5'd0, 32'h8000_0000, 32'd31, 1'b1, 1'b1, 32'd1, "srl");
        alu(4'd7, 5'd8, 5'd0, 5'd0, 32'h8000_0000, 32'd4, 1'b1, 1'b1, 32'hF800_0000, "sra");
        alu(4'd8, 5'd9, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd1, "slt");
        alu(4'd9, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd0, "sltu");
        alu(4'd8, 5'd11, 5'd0, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, "slt_pos_neg");
        alu(4'd12, 5'd12, 5'd0, 5'd0, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, "illegal12");
        bubble(); tick();

        // Forwarding: x4 = x3 + x3 with stale register data
        alu(4'd0, 5'd3, 5'd0, 5'd0, 32'd1, 32'd2, 1'b1, 1'b1, 32'd3, "fwd_x3");
`ifdef EX_FWD_EN
        alu(4'd0, 5'd4, 5'd3, 5'd3, 32'd0, 32'd0, 1'b1, 1'b1, 32'd6, "fwd_x4");
`else
        alu(4'd0, 5'd4, 5'd3, 5'd3, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, "fwd_x4");
`endif
        alu(4'd0, 5'd0, 5'd0, 5'd0, 32'd1, 32'd2, 1'b1, 1'b1, 32'd3, "x0_write");
        alu(4'd0, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, "x0_no_fwd");
        bubble(); tick();

        // Stall in IDLE holds output; flush beats stall
        alu(4'd0, 5'd21, 5'd0, 5'd0, 32'd100, 32'd1, 1'b1, 1'b1, 32'd101, "pre_stall");
        stall = 1'b1; flush = 1'b0; alu_op = 4'd0; reg_wr = 1'b1; reg_addr_rd = 5'd22;
        reg_data_r1 = 32'd200; reg_data_r2 = 32'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_rd", {27'd0, out_reg_addr_rd}, 32'd21);
        end
        q.push_back('{1'b1, 5'd22, 32'd202, "post_stall"});
        stall = 1'b0;
        tick();
        stall = 1'b1; bubble();
        tick();
        check("flush_over_stall", {31'd0, out_flush}, 32'd1);
        stall = 1'b0;
        tick();

        run_mul(32'h0001_0003, 32'h0000_0005, 5'd13, 32'h0005_000F, 0, 0, 33, "mul_basic");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0001, 0, 0, 33, "mul_ones");
        run_mul(32'd3, 32'd4, 5'd15, 32'd12, 4, 0, 37, "mul_stall_done");
        run_mul(32'd7, 32'd6, 5'd16, 32'd42, 0, 5, 38, "mul_en_gap");

        // Flush during MUL discards the result
        flush = 1'b0; alu_op = 4'd10; reg_wr = 1'b1; reg_addr_rd = 5'd20;
        reg_data_r1 = 32'd9; reg_data_r2 = 32'd9;
        tick();
        for (int i = 1; i < 10; i++) tick();
        bubble();
        tick();
        check("mul_flush_busy", {31'd0, out_busy},   32'd0);
        check("mul_flush_out",  {31'd0, out_flush},  32'd1);
        check("mul_flush_wr",   {31'd0, out_reg_wr}, 32'd0);
        repeat (40) tick();

        // Reset during MUL
        alu(4'd0, 5'd17, 5'd0, 5'd0, 32'd5, 32'd6, 1'b1, 1'b1, 32'd11, "pre_rst");
        flush = 1'b0; alu_op = 4'd10; reg_wr = 1'b1; reg_addr_rd = 5'd18;
        tick();
        repeat (5) tick();
        rst = 1'b1; bubble();
        tick();
        check("rst_mid_busy",   {31'd0, out_busy},  32'd0);
        check("rst_mid_result", out_result,         32'd0);
        check("rst_mid_flush",  {31'd0, out_flush}, 32'd1);
        rst = 1'b0;
        repeat (40) tick();

        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
